// File: rtl/pkt_fifo_pkg.sv
// Shared constants and Gray-code helpers for the packet async FIFO.
// Helpers work on 32-bit vectors; callers zero-extend and slice to pointer width.
package pkt_fifo_pkg;

  localparam int DEF_WA = 4;
  localparam int DEF_WD = 8;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync2.sv
// Two-flop synchroniser for a Gray-coded pointer into the clk domain.
// Latency: 2 clk edges; no flow control.
module gray_sync2 #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pkt_async_fifo.sv
// Packet-aware async FIFO: only whole committed packets cross to rd_clk; drop/overflow rewind to the commit point.
// FWFT read, empty falls 2-3 rd_clk edges after commit; writes while full are lost and poison the open packet.
// Optional wr_level/rd_level outputs under PKT_FIFO_LEVEL_EN.
module pkt_async_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int          WA     = DEF_WA,
  parameter int          WD     = DEF_WD,
  parameter int unsigned AF_GAP = 2
) (
  input  logic          rst,
  input  logic          wr_clk,
  input  logic          rd_clk,
  input  logic          wr_en,
  input  logic [WD-1:0] din,
  input  logic          wr_last,
  input  logic          wr_drop,
  output logic          full,
  output logic          almost_full,
  output logic          wr_overflow,
  input  logic          rd_en,
  output logic [WD-1:0] dout,
  output logic          rd_last,
  output logic          empty
`ifdef PKT_FIFO_LEVEL_EN
  ,
  output logic [WA:0]   wr_level,
  output logic [WA:0]   rd_level
`endif
);

  localparam logic [WA:0] DEPTH = (WA+1)'(1 << WA);
  localparam logic [WA:0] ONE   = (WA+1)'(1);

  logic [WD:0] ram [2**WA];

  // ---------------- write domain ----------------
  logic [WA:0] wadr, cadr, cadr_g;
  logic [WA:0] wadr_n, cadr_n;
  logic        ovf, ovf_n, ovfp_n, wr_we;
  logic [WA:0] rsync_g, rsync, wused, wfree, wadr_inc;

  assign wadr_inc    = wadr + ONE;
  assign rsync       = (WA+1)'(gray2bin(32'(rsync_g)));
  assign full        = (wadr == {~rsync[WA], rsync[WA-1:0]});
  assign wused       = wadr - rsync;
  assign wfree       = DEPTH - wused;
  assign almost_full = (32'(wfree) <= AF_GAP);

  always_comb begin
    wadr_n = wadr;
    cadr_n = cadr;
    ovf_n  = ovf;
    ovfp_n = 1'b0;
    wr_we  = 1'b0;
    if (wr_drop) begin
      wadr_n = cadr;
      ovf_n  = 1'b0;
    end else if (wr_en) begin
      // A packet that lost any word (including its last) is discarded whole.
      if (wr_last && (ovf || full)) begin
        wadr_n = cadr;
        ovf_n  = 1'b0;
        ovfp_n = 1'b1;
      end else if (full) begin
        ovf_n = 1'b1;
      end else begin
        wr_we  = 1'b1;
        wadr_n = wadr_inc;
        if (wr_last) cadr_n = wadr_inc;
      end
    end
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      wadr        <= '0;
      cadr        <= '0;
      cadr_g      <= '0;
      ovf         <= 1'b0;
      wr_overflow <= 1'b0;
    end else begin
      wadr        <= wadr_n;
      cadr        <= cadr_n;
      cadr_g      <= (WA+1)'(bin2gray(32'(cadr_n)));
      ovf         <= ovf_n;
      wr_overflow <= ovfp_n;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_we) ram[wadr[WA-1:0]] <= {wr_last, din};
  end

  // ---------------- read domain ----------------
  logic [WA:0] radr, radr_g, radr_inc, csync_g, csync;
  logic [WD:0] rd_word;

  assign csync    = (WA+1)'(gray2bin(32'(csync_g)));
  assign empty    = (radr == csync);
  assign radr_inc = radr + ONE;
  assign rd_word  = ram[radr[WA-1:0]];
  assign dout     = empty ? '0 : rd_word[WD-1:0];
  assign rd_last  = ~empty & rd_word[WD];

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      radr   <= '0;
      radr_g <= '0;
    end else if (rd_en && !empty) begin
      radr   <= radr_inc;
      radr_g <= (WA+1)'(bin2gray(32'(radr_inc)));
    end
  end

  gray_sync2 #(.W(WA+1)) u_sync_rd2wr (
    .clk (wr_clk),
    .rst (rst),
    .d   (radr_g),
    .q   (rsync_g)
  );

  gray_sync2 #(.W(WA+1)) u_sync_wr2rd (
    .clk (rd_clk),
    .rst (rst),
    .d   (cadr_g),
    .q   (csync_g)
  );

`ifdef PKT_FIFO_LEVEL_EN
  assign wr_level = wused;
  assign rd_level = csync - radr;
`endif

endmodule

// File: tb/tb_pkt_async_fifo.sv
// Scoreboard bench for pkt_async_fifo: directed packet scenarios plus random packets/drops.
// wr_clk 125 MHz, rd_clk 100 MHz; level checks only when PKT_FIFO_LEVEL_EN is defined.
module tb_pkt_async_fifo;

  localparam int WA = 4;
  localparam int WD = 8;

  logic          rst, wr_clk, rd_clk;
  logic          wr_en, wr_last, wr_drop, rd_en;
  logic [WD-1:0] din, dout;
  logic          full, almost_full, wr_overflow, rd_last, empty;
`ifdef PKT_FIFO_LEVEL_EN
  logic [WA:0]   wr_level, rd_level;
`endif

  pkt_async_fifo #(.WA(WA), .WD(WD), .AF_GAP(2)) dut (
    .rst         (rst),
    .wr_clk      (wr_clk),
    .rd_clk      (rd_clk),
    .wr_en       (wr_en),
    .din         (din),
    .wr_last     (wr_last),
    .wr_drop     (wr_drop),
    .full        (full),
    .almost_full (almost_full),
    .wr_overflow (wr_overflow),
    .rd_en       (rd_en),
    .dout        (dout),
    .rd_last     (rd_last),
    .empty       (empty)
`ifdef PKT_FIFO_LEVEL_EN
    ,
    .wr_level    (wr_level),
    .rd_level    (rd_level)
`endif
  );

  initial wr_clk = 1'b0;
  initial rd_clk = 1'b0;
  always #4 wr_clk = ~wr_clk;
  always #5 rd_clk = ~rd_clk;

  typedef struct packed {
    logic          last;
    logic [WD-1:0] d;
  } word_t;

  word_t exp_q[$];   // committed words the reader must see, in order
  word_t pend_q[$];  // open packet, not yet readable
  int    n_chk    = 0;
  int    n_fail   = 0;
  int    rd_quota = 0;
  int    ovf_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge wr_clk);
    #1;
  endtask

  // Model: words become readable only when their packet's last word is accepted.
  task automatic wr_word(input logic [WD-1:0] d, input logic last);
    int g = 0;
    while (full && g < 500) begin
      @(posedge wr_clk);
      #1;
      g++;
    end
    if (g >= 500) timeout("wr_stall");
    wr_en = 1'b1; din = d; wr_last = last;
    @(posedge wr_clk);
    #1;
    wr_en = 1'b0; wr_last = 1'b0;
    pend_q.push_back('{last: last, d: d});
    if (last) begin
      foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
      pend_q.delete();
    end
  endtask

  // Unmodelled write used for the overflow scenario, where nothing may become readable.
  task automatic wr_raw(input logic [WD-1:0] d, input logic last);
    wr_en = 1'b1; din = d; wr_last = last;
    @(posedge wr_clk);
    #1;
    wr_en = 1'b0; wr_last = 1'b0;
  endtask

  task automatic do_drop();
    wr_drop = 1'b1;
    @(posedge wr_clk);
    #1;
    wr_drop = 1'b0;
    pend_q.delete();
  endtask

  task automatic drain(input string name);
    int g = 0;
    rd_quota = 1000;
    while (!(exp_q.size() == 0 && empty) && g < 600) begin
      @(posedge rd_clk);
      #2;
      g++;
    end
    if (g >= 600) timeout(name);
    rd_quota = 0;
    @(posedge rd_clk);
    #2;
    check({name, "_empty"}, empty, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_full"},        full, 0);
    check({tag, "_almost_full"}, almost_full, 0);
    check({tag, "_wr_overflow"}, wr_overflow, 0);
    check({tag, "_empty"},       empty, 1);
    check({tag, "_dout"},        dout, 0);
    check({tag, "_rd_last"},     rd_last, 0);
`ifdef PKT_FIFO_LEVEL_EN
    check({tag, "_wr_level"},    wr_level, 0);
    check({tag, "_rd_level"},    rd_level, 0);
`endif
  endtask

  // Reader: random rd_en while it has quota.
  initial begin
    rd_en = 1'b0;
    forever begin
      @(posedge rd_clk);
      #1;
      rd_en = (rd_quota > 0) && ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every word the DUT hands over is compared with the scoreboard head.
  initial begin
    word_t w;
    forever begin
      @(negedge rd_clk);
      if (rd_en && !empty && !rst) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rd_unexpected: got %0h last=%0b, expected no word", dout, rd_last);
        end else begin
          w = exp_q.pop_front();
          check("rd_data", dout, w.d);
          check("rd_last", rd_last, w.last);
        end
        if (rd_quota > 0) rd_quota--;
      end
    end
  end

  always @(negedge wr_clk) if (wr_overflow) ovf_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, g, len, drop_at;
    rst = 1'b1; wr_en = 1'b0; wr_last = 1'b0; wr_drop = 1'b0; din = '0;
    #23;
    check_reset_outputs("reset");
    @(negedge wr_clk);
    rst = 1'b0;
    settle(2);

    // Three-word packet: invisible until committed, then readable in order.
    wr_word(8'hA1, 1'b0);
    wr_word(8'hA2, 1'b0);
    settle(5);
    check("uncommitted_empty", empty, 1);
    wr_word(8'hA3, 1'b1);
    edges = 0;
    while (empty && edges < 8) begin
      @(posedge rd_clk);
      #1;
      edges++;
    end
    n_chk++;
    if (empty || edges > 3) begin
      n_fail++;
      $display("FAIL empty_fall: got %0d rd edges (empty=%0b), expected <= 3", edges, empty);
    end
    drain("pkt_a");

    // Dropped packet leaves no trace.
    wr_word(8'hD1, 1'b0);
    wr_word(8'hD2, 1'b0);
    do_drop();
    settle(6);
    check("drop_empty", empty, 1);
    wr_word(8'hB1, 1'b1);
    drain("pkt_b");

    // 20-word packet into 16 words: overflow discards the whole packet.
    settle(6);
    ovf_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      wr_raw(WD'(i), i == 20);
      if (i == 15) check("ovf_full_at15", full, 0);
      if (i == 16) check("ovf_full_at16", full, 1);
      if (i == 19) check("ovf_no_pulse_yet", wr_overflow, 0);
      if (i == 20) begin
        check("ovf_pulse", wr_overflow, 1);
        check("ovf_full_cleared", full, 0);
      end
    end
    settle(6);
    check("ovf_pulse_count", ovf_cnt, 1);
    check("ovf_pulse_gone", wr_overflow, 0);
    check("ovf_empty", empty, 1);

    // almost_full boundary: 13 words -> 3 free, 14 words -> 2 free.
    for (int i = 0; i < 14; i++) begin
      wr_word(WD'(8'h40 + i), i == 13);
      if (i == 12) begin
        settle(1);
        check("af_13_words", almost_full, 0);
      end
    end
    settle(2);
    check("af_14_words", almost_full, 1);
    check("af_not_full", full, 0);
    rd_quota = 2;
    g = 0;
    while (rd_quota > 0 && g < 200) begin
      @(posedge rd_clk);
      g++;
    end
    if (rd_quota > 0) timeout("af_reads");
    @(posedge rd_clk);
    settle(6);
    check("af_after_2_reads", almost_full, 0);
    drain("pkt_af");

`ifdef PKT_FIFO_LEVEL_EN
    settle(6);
    for (int i = 0; i < 5; i++) wr_word(WD'(8'h50 + i), i == 4);
    settle(1);
    check("wr_level_5", wr_level, 5);
    settle(6);
    check("rd_level_5", rd_level, 5);
    drain("pkt_level");
`endif

    // Reset while a packet is open and the reader is mid-packet.
    settle(6);
    for (int i = 0; i < 10; i++) wr_word(WD'(8'h60 + i), i == 9);
    wr_word(8'h70, 1'b0);
    wr_word(8'h71, 1'b0);
    rd_quota = 3;
    g = 0;
    while (rd_quota > 1 && g < 200) begin
      @(posedge rd_clk);
      g++;
    end
    if (rd_quota > 1) timeout("mid_read");
    @(posedge rd_clk);
    #3;
    rst = 1'b1;
    rd_quota = 0;
    exp_q.delete();
    pend_q.delete();
    #1;
    check_reset_outputs("midrst");
    #20;
    rst = 1'b0;
    settle(8);
    check("postrst_empty", empty, 1);
    wr_word(8'h81, 1'b0);
    wr_word(8'h82, 1'b0);
    wr_word(8'h83, 1'b1);
    drain("pkt_postrst");

    // Random packets with occasional drops, reader running concurrently.
    rd_quota = 100000;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 6);
      drop_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len) : 0;
      for (int j = 1; j <= len; j++) begin
        if (j == drop_at) begin
          do_drop();
          break;
        end
        wr_word(WD'($urandom), j == len);
      end
      if ($urandom_range(0, 1) == 1) settle($urandom_range(1, 4));
    end
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
